// File: rtl/dispatch_ctrl_pkg.sv
// dispatch_ctrl_pkg
// Shared definitions for the dispatch stage: opcode-number (OPNUM) codes
// produced by the instruction decoder, boolean helpers, the zero register
// index and the dispatch FSM state encoding.
package dispatch_ctrl_pkg;

  localparam int OPNUM_W = 6;

  localparam logic       TRUE     = 1'b1;
  localparam logic       FALSE    = 1'b0;
  localparam logic [4:0] ZERO_REG = 5'd0;

  // OPNUM codes; OP_NULL marks an undecodable / empty instruction
  localparam logic [OPNUM_W-1:0] OP_NULL  = 6'd0;
  localparam logic [OPNUM_W-1:0] OP_LUI   = 6'd1;
  localparam logic [OPNUM_W-1:0] OP_AUIPC = 6'd2;
  localparam logic [OPNUM_W-1:0] OP_JAL   = 6'd3;
  localparam logic [OPNUM_W-1:0] OP_JALR  = 6'd4;
  localparam logic [OPNUM_W-1:0] OP_BEQ   = 6'd5;
  localparam logic [OPNUM_W-1:0] OP_BNE   = 6'd6;
  localparam logic [OPNUM_W-1:0] OP_BLT   = 6'd7;
  localparam logic [OPNUM_W-1:0] OP_BGE   = 6'd8;
  localparam logic [OPNUM_W-1:0] OP_BLTU  = 6'd9;
  localparam logic [OPNUM_W-1:0] OP_BGEU  = 6'd10;
  localparam logic [OPNUM_W-1:0] OP_LB    = 6'd11;
  localparam logic [OPNUM_W-1:0] OP_LH    = 6'd12;
  localparam logic [OPNUM_W-1:0] OP_LW    = 6'd13;
  localparam logic [OPNUM_W-1:0] OP_LBU   = 6'd14;
  localparam logic [OPNUM_W-1:0] OP_LHU   = 6'd15;
  localparam logic [OPNUM_W-1:0] OP_SB    = 6'd16;
  localparam logic [OPNUM_W-1:0] OP_SH    = 6'd17;
  localparam logic [OPNUM_W-1:0] OP_SW    = 6'd18;
  localparam logic [OPNUM_W-1:0] OP_ADDI  = 6'd19;
  localparam logic [OPNUM_W-1:0] OP_SLTI  = 6'd20;
  localparam logic [OPNUM_W-1:0] OP_SLTIU = 6'd21;
  localparam logic [OPNUM_W-1:0] OP_XORI  = 6'd22;
  localparam logic [OPNUM_W-1:0] OP_ORI   = 6'd23;
  localparam logic [OPNUM_W-1:0] OP_ANDI  = 6'd24;
  localparam logic [OPNUM_W-1:0] OP_SLLI  = 6'd25;
  localparam logic [OPNUM_W-1:0] OP_SRLI  = 6'd26;
  localparam logic [OPNUM_W-1:0] OP_SRAI  = 6'd27;
  localparam logic [OPNUM_W-1:0] OP_ADD   = 6'd28;
  localparam logic [OPNUM_W-1:0] OP_SUB   = 6'd29;
  localparam logic [OPNUM_W-1:0] OP_SLL   = 6'd30;
  localparam logic [OPNUM_W-1:0] OP_SLT   = 6'd31;
  localparam logic [OPNUM_W-1:0] OP_SLTU  = 6'd32;
  localparam logic [OPNUM_W-1:0] OP_XOR   = 6'd33;
  localparam logic [OPNUM_W-1:0] OP_SRL   = 6'd34;
  localparam logic [OPNUM_W-1:0] OP_SRA   = 6'd35;
  localparam logic [OPNUM_W-1:0] OP_OR    = 6'd36;
  localparam logic [OPNUM_W-1:0] OP_AND   = 6'd37;

  typedef enum logic [1:0] {
    DSP_EMPTY = 2'd0,
    DSP_FULL  = 2'd1,
    DSP_BLOCK = 2'd2
  } dsp_state_e;

endpackage

// File: rtl/dispatch_ctrl_decoder.sv
// dispatch_ctrl_decoder
// Purely combinational RV32I decoder used on the instruction held in the
// dispatch register.
// Ports:
//   inst_i     : 32-bit instruction word
//   opnum_o    : OPNUM code (OP_NULL when not a supported instruction)
//   rd_o/rs1_o/rs2_o : register indices, zero when the format has no such field
//   imm_o      : sign-extended immediate for the format
//   is_ls_o    : load or store (goes to the load/store buffer)
//   is_store_o : store
module dispatch_ctrl_decoder
  import dispatch_ctrl_pkg::*;
(
  input  logic [31:0]        inst_i,
  output logic [OPNUM_W-1:0] opnum_o,
  output logic [4:0]         rd_o,
  output logic [4:0]         rs1_o,
  output logic [4:0]         rs2_o,
  output logic [31:0]        imm_o,
  output logic               is_ls_o,
  output logic               is_store_o
);

  logic [6:0] opcode_s;
  logic [2:0] f3_s;
  logic [6:0] f7_s;
  logic       use_rd_s;
  logic       use_rs1_s;
  logic       use_rs2_s;
  logic [31:0] imm_i_s;
  logic [31:0] imm_s_s;
  logic [31:0] imm_b_s;
  logic [31:0] imm_u_s;
  logic [31:0] imm_j_s;

  assign opcode_s = inst_i[6:0];
  assign f3_s     = inst_i[14:12];
  assign f7_s     = inst_i[31:25];
  assign imm_i_s  = {{20{inst_i[31]}}, inst_i[31:20]};
  assign imm_s_s  = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
  assign imm_b_s  = {{19{inst_i[31]}}, inst_i[31], inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0};
  assign imm_u_s  = {inst_i[31:12], 12'd0};
  assign imm_j_s  = {{11{inst_i[31]}}, inst_i[31], inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0};

  // Opcode/funct decode; fields are zeroed when the word does not decode
  always_comb begin
    opnum_o    = OP_NULL;
    use_rd_s   = FALSE;
    use_rs1_s  = FALSE;
    use_rs2_s  = FALSE;
    imm_o      = 32'd0;
    is_ls_o    = FALSE;
    is_store_o = FALSE;
    case (opcode_s)
      7'b0110111: begin
        opnum_o = OP_LUI;   use_rd_s = TRUE; imm_o = imm_u_s;
      end
      7'b0010111: begin
        opnum_o = OP_AUIPC; use_rd_s = TRUE; imm_o = imm_u_s;
      end
      7'b1101111: begin
        opnum_o = OP_JAL;   use_rd_s = TRUE; imm_o = imm_j_s;
      end
      7'b1100111: begin
        use_rd_s = TRUE; use_rs1_s = TRUE; imm_o = imm_i_s;
        opnum_o  = (f3_s == 3'b000) ? OP_JALR : OP_NULL;
      end
      7'b1100011: begin
        use_rs1_s = TRUE; use_rs2_s = TRUE; imm_o = imm_b_s;
        case (f3_s)
          3'b000:  opnum_o = OP_BEQ;
          3'b001:  opnum_o = OP_BNE;
          3'b100:  opnum_o = OP_BLT;
          3'b101:  opnum_o = OP_BGE;
          3'b110:  opnum_o = OP_BLTU;
          3'b111:  opnum_o = OP_BGEU;
          default: opnum_o = OP_NULL;
        endcase
      end
      7'b0000011: begin
        use_rd_s = TRUE; use_rs1_s = TRUE; imm_o = imm_i_s; is_ls_o = TRUE;
        case (f3_s)
          3'b000:  opnum_o = OP_LB;
          3'b001:  opnum_o = OP_LH;
          3'b010:  opnum_o = OP_LW;
          3'b100:  opnum_o = OP_LBU;
          3'b101:  opnum_o = OP_LHU;
          default: opnum_o = OP_NULL;
        endcase
      end
      7'b0100011: begin
        use_rs1_s = TRUE; use_rs2_s = TRUE; imm_o = imm_s_s;
        is_ls_o = TRUE; is_store_o = TRUE;
        case (f3_s)
          3'b000:  opnum_o = OP_SB;
          3'b001:  opnum_o = OP_SH;
          3'b010:  opnum_o = OP_SW;
          default: opnum_o = OP_NULL;
        endcase
      end
      7'b0010011: begin
        use_rd_s = TRUE; use_rs1_s = TRUE; imm_o = imm_i_s;
        case (f3_s)
          3'b000:  opnum_o = OP_ADDI;
          3'b010:  opnum_o = OP_SLTI;
          3'b011:  opnum_o = OP_SLTIU;
          3'b100:  opnum_o = OP_XORI;
          3'b110:  opnum_o = OP_ORI;
          3'b111:  opnum_o = OP_ANDI;
          3'b001:  opnum_o = (f7_s == 7'b0000000) ? OP_SLLI : OP_NULL;
          3'b101:  opnum_o = (f7_s == 7'b0000000) ? OP_SRLI :
                             (f7_s == 7'b0100000) ? OP_SRAI : OP_NULL;
          default: opnum_o = OP_NULL;
        endcase
      end
      7'b0110011: begin
        use_rd_s = TRUE; use_rs1_s = TRUE; use_rs2_s = TRUE;
        if (f7_s == 7'b0000000) begin
          case (f3_s)
            3'b000:  opnum_o = OP_ADD;
            3'b001:  opnum_o = OP_SLL;
            3'b010:  opnum_o = OP_SLT;
            3'b011:  opnum_o = OP_SLTU;
            3'b100:  opnum_o = OP_XOR;
            3'b101:  opnum_o = OP_SRL;
            3'b110:  opnum_o = OP_OR;
            3'b111:  opnum_o = OP_AND;
            default: opnum_o = OP_NULL;
          endcase
        end else if (f7_s == 7'b0100000) begin
          case (f3_s)
            3'b000:  opnum_o = OP_SUB;
            3'b101:  opnum_o = OP_SRA;
            default: opnum_o = OP_NULL;
          endcase
        end else begin
          opnum_o = OP_NULL;
        end
      end
      default: opnum_o = OP_NULL;
    endcase

    // An undecodable word carries no payload at all
    if (opnum_o == OP_NULL) begin
      use_rd_s   = FALSE;
      use_rs1_s  = FALSE;
      use_rs2_s  = FALSE;
      imm_o      = 32'd0;
      is_ls_o    = FALSE;
      is_store_o = FALSE;
    end else begin
      imm_o = imm_o;
    end
  end

  assign rd_o  = use_rd_s  ? inst_i[11:7]  : ZERO_REG;
  assign rs1_o = use_rs1_s ? inst_i[19:15] : ZERO_REG;
  assign rs2_o = use_rs2_s ? inst_i[24:20] : ZERO_REG;

endmodule

// File: rtl/dispatch_ctrl.sv
// dispatch_ctrl
// Dispatch stage: pops the IQ head into a one-entry register, decodes it and
// issues it to the ROB plus either the RS or the LSB. Stalls on full
// resources, blocks fetch after a JALR until jalr_done, flushes on rollback.
// Ports:
//   clk, rst (async, active-high), rdy (global enable)
//   iq_valid/iq_inst/iq_pc/iq_pred_jump in, iq_pop out : IQ head handshake
//   rob_full/rs_full/lsb_full, rob_free_tag in        : back-end resources
//   rob_en/rs_en/lsb_en out                           : dispatch strobes
//   d_* out                                           : dispatch payload
//   rollback, jalr_done in                            : flush / JALR resolve
// Optional feature (macro DISPATCH_STATS_EN): stat_dispatch_cnt and
// stat_stall_cnt 32-bit counters, cleared only by rst.
module dispatch_ctrl
  import dispatch_ctrl_pkg::*;
#(
  parameter int ROB_IDX_W = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rdy,
  input  logic                 iq_valid,
  input  logic [31:0]          iq_inst,
  input  logic [31:0]          iq_pc,
  input  logic                 iq_pred_jump,
  output logic                 iq_pop,
  input  logic                 rob_full,
  input  logic                 rs_full,
  input  logic                 lsb_full,
  input  logic [ROB_IDX_W-1:0] rob_free_tag,
  output logic                 rob_en,
  output logic                 rs_en,
  output logic                 lsb_en,
  output logic [OPNUM_W-1:0]   d_opnum,
  output logic [4:0]           d_rd,
  output logic [4:0]           d_rs1,
  output logic [4:0]           d_rs2,
  output logic [31:0]          d_imm,
  output logic [31:0]          d_pc,
  output logic                 d_pred_jump,
  output logic                 d_is_store,
  output logic [ROB_IDX_W-1:0] d_tag,
  input  logic                 rollback,
  input  logic                 jalr_done
`ifdef DISPATCH_STATS_EN
  ,
  output logic [31:0]          stat_dispatch_cnt,
  output logic [31:0]          stat_stall_cnt
`endif
);

  dsp_state_e state_q, state_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] pc_q, pc_d;
  logic        pred_q, pred_d;

  logic       is_ls_s;
  logic       held_s;
  logic       is_null_s;
  logic       res_full_s;
  logic       fire_s;
  logic       drop_s;
  logic       is_jalr_s;
  logic       pop_s;

  dispatch_ctrl_decoder u_decoder (
    .inst_i     (inst_q),
    .opnum_o    (d_opnum),
    .rd_o       (d_rd),
    .rs1_o      (d_rs1),
    .rs2_o      (d_rs2),
    .imm_o      (d_imm),
    .is_ls_o    (is_ls_s),
    .is_store_o (d_is_store)
  );

  assign held_s     = (state_q == DSP_FULL);
  assign is_null_s  = (d_opnum == OP_NULL);
  assign is_jalr_s  = (d_opnum == OP_JALR);
  assign res_full_s = rob_full | (is_ls_s ? lsb_full : rs_full);
  assign fire_s     = held_s & rdy & ~rollback & ~is_null_s & ~res_full_s;
  assign drop_s     = held_s & rdy & ~rollback & is_null_s;
  // A dispatching JALR must not pull in the next instruction: fetch past it
  // is speculative until the target resolves.
  assign pop_s      = rdy & ~rollback & iq_valid &
                      ((state_q == DSP_EMPTY) | (fire_s & ~is_jalr_s) | drop_s);

  assign iq_pop      = pop_s;
  assign rob_en      = fire_s;
  assign rs_en       = fire_s & ~is_ls_s;
  assign lsb_en      = fire_s & is_ls_s;
  assign d_pc        = pc_q;
  assign d_pred_jump = pred_q;
  assign d_tag       = rob_free_tag;

  // Next-state and dispatch-register load logic
  always_comb begin
    state_d = state_q;
    inst_d  = inst_q;
    pc_d    = pc_q;
    pred_d  = pred_q;
    if (rollback) begin
      state_d = DSP_EMPTY;
      inst_d  = 32'd0;
      pc_d    = 32'd0;
      pred_d  = 1'b0;
    end else if (!rdy) begin
      state_d = state_q;
    end else begin
      case (state_q)
        DSP_EMPTY: begin
          if (pop_s) begin
            state_d = DSP_FULL;
            inst_d  = iq_inst;
            pc_d    = iq_pc;
            pred_d  = iq_pred_jump;
          end else begin
            state_d = DSP_EMPTY;
          end
        end
        DSP_FULL: begin
          if (fire_s && is_jalr_s) begin
            state_d = DSP_BLOCK;
          end else if (fire_s || drop_s) begin
            if (pop_s) begin
              state_d = DSP_FULL;
              inst_d  = iq_inst;
              pc_d    = iq_pc;
              pred_d  = iq_pred_jump;
            end else begin
              state_d = DSP_EMPTY;
              inst_d  = 32'd0;
              pc_d    = 32'd0;
              pred_d  = 1'b0;
            end
          end else begin
            state_d = DSP_FULL;
          end
        end
        DSP_BLOCK: begin
          if (jalr_done) begin
            state_d = DSP_EMPTY;
            inst_d  = 32'd0;
            pc_d    = 32'd0;
            pred_d  = 1'b0;
          end else begin
            state_d = DSP_BLOCK;
          end
        end
        default: begin
          state_d = DSP_EMPTY;
          inst_d  = 32'd0;
          pc_d    = 32'd0;
          pred_d  = 1'b0;
        end
      endcase
    end
  end

  // State and dispatch-register flops
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= DSP_EMPTY;
      inst_q  <= 32'd0;
      pc_q    <= 32'd0;
      pred_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      inst_q  <= inst_d;
      pc_q    <= pc_d;
      pred_q  <= pred_d;
    end
  end

`ifdef DISPATCH_STATS_EN
  logic stall_s;
  assign stall_s = held_s & rdy & ~rollback & ~is_null_s & ~fire_s;

  // Dispatch and stall counters; rollback deliberately leaves them intact
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_dispatch_cnt <= 32'd0;
      stat_stall_cnt    <= 32'd0;
    end else begin
      stat_dispatch_cnt <= stat_dispatch_cnt + {31'd0, fire_s};
      stat_stall_cnt    <= stat_stall_cnt + {31'd0, stall_s};
    end
  end
`endif

endmodule

// File: tb/tb_dispatch_ctrl.sv
module tb_dispatch_ctrl;
  import dispatch_ctrl_pkg::*;

  localparam logic [31:0] ADDI_X1_5  = 32'h00500093;
  localparam logic [31:0] SW_X2_8_X1 = 32'h0020A423;
  localparam logic [31:0] JALR_X1_X1 = 32'h000080E7;

  logic        clk;
  logic        rst;
  logic        rdy;
  logic        iq_valid;
  logic [31:0] iq_inst;
  logic [31:0] iq_pc;
  logic        iq_pred_jump;
  logic        iq_pop;
  logic        rob_full, rs_full, lsb_full;
  logic [3:0]  rob_free_tag;
  logic        rob_en, rs_en, lsb_en;
  logic [OPNUM_W-1:0] d_opnum;
  logic [4:0]  d_rd, d_rs1, d_rs2;
  logic [31:0] d_imm, d_pc;
  logic        d_pred_jump, d_is_store;
  logic [3:0]  d_tag;
  logic        rollback, jalr_done;
`ifdef DISPATCH_STATS_EN
  logic [31:0] stat_dispatch_cnt, stat_stall_cnt;
`endif

  int checks;
  int errors;

  dispatch_ctrl #(.ROB_IDX_W(4)) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .iq_valid(iq_valid), .iq_inst(iq_inst), .iq_pc(iq_pc),
    .iq_pred_jump(iq_pred_jump), .iq_pop(iq_pop),
    .rob_full(rob_full), .rs_full(rs_full), .lsb_full(lsb_full),
    .rob_free_tag(rob_free_tag),
    .rob_en(rob_en), .rs_en(rs_en), .lsb_en(lsb_en),
    .d_opnum(d_opnum), .d_rd(d_rd), .d_rs1(d_rs1), .d_rs2(d_rs2),
    .d_imm(d_imm), .d_pc(d_pc), .d_pred_jump(d_pred_jump),
    .d_is_store(d_is_store), .d_tag(d_tag),
    .rollback(rollback), .jalr_done(jalr_done)
`ifdef DISPATCH_STATS_EN
    , .stat_dispatch_cnt(stat_dispatch_cnt), .stat_stall_cnt(stat_stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // advance to 1ns after the next rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2;
    checks++; if ({rob_en, rs_en, lsb_en, iq_pop} !== 4'b0000) begin
      errors++; $display("FAIL reset_strobes got %b exp 0000", {rob_en, rs_en, lsb_en, iq_pop}); end
    checks++; if (d_opnum !== OP_NULL) begin
      errors++; $display("FAIL reset_opnum got %0d exp %0d", d_opnum, OP_NULL); end
    checks++; if ({d_rd, d_imm, d_pc, d_pred_jump} !== 43'd0) begin
      errors++; $display("FAIL reset_payload rd=%0d imm=%h pc=%h pred=%b exp all 0", d_rd, d_imm, d_pc, d_pred_jump); end
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic test_addi();
    iq_valid = 1'b1; iq_inst = ADDI_X1_5; iq_pc = 32'h100; iq_pred_jump = 1'b0;
    rob_free_tag = 4'd3;
    #1;
    checks++; if (iq_pop !== 1'b1) begin
      errors++; $display("FAIL addi_pop got %b exp 1", iq_pop); end
    step();
    iq_valid = 1'b0;
    #1;
    checks++; if ({rob_en, rs_en, lsb_en} !== 3'b110) begin
      errors++; $display("FAIL addi_strobes got %b exp 110", {rob_en, rs_en, lsb_en}); end
    checks++; if (d_opnum !== OP_ADDI || d_rd !== 5'd1 || d_rs1 !== 5'd0 || d_imm !== 32'd5) begin
      errors++; $display("FAIL addi_payload op=%0d rd=%0d rs1=%0d imm=%0d exp %0d 1 0 5", d_opnum, d_rd, d_rs1, d_imm, OP_ADDI); end
    checks++; if (d_tag !== 4'd3 || d_pc !== 32'h100) begin
      errors++; $display("FAIL addi_tag_pc tag=%0d pc=%h exp 3 100", d_tag, d_pc); end
    step();
    checks++; if (rob_en !== 1'b0) begin
      errors++; $display("FAIL addi_after got %b exp 0", rob_en); end
  endtask

  task automatic test_store();
    iq_valid = 1'b1; iq_inst = SW_X2_8_X1; iq_pc = 32'h104; iq_pred_jump = 1'b1;
    rob_free_tag = 4'd7;
    step();
    iq_valid = 1'b0;
    #1;
    checks++; if ({rob_en, rs_en, lsb_en, d_is_store} !== 4'b1011) begin
      errors++; $display("FAIL sw_strobes got %b exp 1011", {rob_en, rs_en, lsb_en, d_is_store}); end
    checks++; if (d_opnum !== OP_SW || d_rd !== 5'd0 || d_rs1 !== 5'd1 || d_rs2 !== 5'd2 || d_imm !== 32'd8) begin
      errors++; $display("FAIL sw_payload op=%0d rd=%0d rs1=%0d rs2=%0d imm=%0d exp %0d 0 1 2 8", d_opnum, d_rd, d_rs1, d_rs2, d_imm, OP_SW); end
    checks++; if (d_pred_jump !== 1'b1 || d_tag !== 4'd7) begin
      errors++; $display("FAIL sw_pred_tag pred=%b tag=%0d exp 1 7", d_pred_jump, d_tag); end
    step();
  endtask

  task automatic test_stall();
    iq_valid = 1'b1; iq_inst = ADDI_X1_5; iq_pc = 32'h200; iq_pred_jump = 1'b0;
    step();
    iq_inst = 32'h00A00113; iq_pc = 32'h204;  // ADDI x2,x0,10 queued behind
    rs_full = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if ({rob_en, rs_en, lsb_en, iq_pop} !== 4'b0000) begin
        errors++; $display("FAIL stall_strobes_%0d got %b exp 0000", i, {rob_en, rs_en, lsb_en, iq_pop}); end
      checks++; if (d_pc !== 32'h200 || d_imm !== 32'd5 || d_opnum !== OP_ADDI) begin
        errors++; $display("FAIL stall_payload_%0d pc=%h imm=%0d exp 200 5", i, d_pc, d_imm); end
      step();
    end
    rs_full = 1'b0;
    #1;
    checks++; if ({rob_en, rs_en, iq_pop} !== 3'b111 || d_pc !== 32'h200) begin
      errors++; $display("FAIL stall_release got %b pc=%h exp 111 200", {rob_en, rs_en, iq_pop}, d_pc); end
    step();
    iq_valid = 1'b0;
    #1;
    checks++; if (rob_en !== 1'b1 || d_pc !== 32'h204 || d_rd !== 5'd2 || d_imm !== 32'd10) begin
      errors++; $display("FAIL back_to_back en=%b pc=%h rd=%0d imm=%0d exp 1 204 2 10", rob_en, d_pc, d_rd, d_imm); end
    step();
`ifdef DISPATCH_STATS_EN
    checks++; if (stat_stall_cnt !== 32'd3) begin
      errors++; $display("FAIL stat_stall got %0d exp 3", stat_stall_cnt); end
    checks++; if (stat_dispatch_cnt !== 32'd4) begin
      errors++; $display("FAIL stat_dispatch got %0d exp 4", stat_dispatch_cnt); end
`endif
  endtask

  task automatic test_jalr();
    iq_valid = 1'b1; iq_inst = JALR_X1_X1; iq_pc = 32'h300;
    step();
    iq_inst = ADDI_X1_5; iq_pc = 32'h304;
    #1;
    checks++; if ({rob_en, rs_en, lsb_en, iq_pop} !== 4'b1100) begin
      errors++; $display("FAIL jalr_fire got %b exp 1100", {rob_en, rs_en, lsb_en, iq_pop}); end
    checks++; if (d_opnum !== OP_JALR || d_rd !== 5'd1 || d_rs1 !== 5'd1 || d_imm !== 32'd0) begin
      errors++; $display("FAIL jalr_payload op=%0d rd=%0d rs1=%0d imm=%0d", d_opnum, d_rd, d_rs1, d_imm); end
    step();
    for (int i = 0; i < 5; i++) begin
      checks++; if (iq_pop !== 1'b0 || rob_en !== 1'b0) begin
        errors++; $display("FAIL jalr_block_%0d pop=%b en=%b exp 0 0", i, iq_pop, rob_en); end
      step();
    end
    jalr_done = 1'b1;
    #1;
    checks++; if (iq_pop !== 1'b0) begin
      errors++; $display("FAIL jalr_done_pop got %b exp 0", iq_pop); end
    step();
    jalr_done = 1'b0;
    #1;
    checks++; if (iq_pop !== 1'b1) begin
      errors++; $display("FAIL jalr_resume_pop got %b exp 1", iq_pop); end
    step();
    iq_valid = 1'b0;
    #1;
    checks++; if (rob_en !== 1'b1 || d_pc !== 32'h304) begin
      errors++; $display("FAIL jalr_next en=%b pc=%h exp 1 304", rob_en, d_pc); end
    step();
  endtask

  task automatic test_rollback();
    iq_valid = 1'b1; iq_inst = ADDI_X1_5; iq_pc = 32'h400;
    step();
    rob_full = 1'b1; rollback = 1'b1;
    #1;
    checks++; if ({rob_en, rs_en, lsb_en, iq_pop} !== 4'b0000) begin
      errors++; $display("FAIL rollback_same got %b exp 0000", {rob_en, rs_en, lsb_en, iq_pop}); end
    step();
    rollback = 1'b0; rob_full = 1'b0; iq_valid = 1'b0;
    #1;
    checks++; if ({rob_en, rs_en, lsb_en} !== 3'b000) begin
      errors++; $display("FAIL rollback_next got %b exp 000", {rob_en, rs_en, lsb_en}); end
    iq_valid = 1'b1;
    #1;
    checks++; if (iq_pop !== 1'b1) begin
      errors++; $display("FAIL rollback_empty_pop got %b exp 1", iq_pop); end
    step();
    iq_valid = 1'b0;
    step();
  endtask

  task automatic test_rdy_low();
    iq_valid = 1'b1; iq_inst = ADDI_X1_5; iq_pc = 32'h480;
    step();
    iq_valid = 1'b0; rdy = 1'b0;
    #1;
    checks++; if ({rob_en, iq_pop} !== 2'b00) begin
      errors++; $display("FAIL rdy_low got %b exp 00", {rob_en, iq_pop}); end
    step();
    rdy = 1'b1;
    #1;
    checks++; if (rob_en !== 1'b1 || d_pc !== 32'h480) begin
      errors++; $display("FAIL rdy_resume en=%b pc=%h exp 1 480", rob_en, d_pc); end
    step();
  endtask

  task automatic test_async_rst();
    iq_valid = 1'b1; iq_inst = ADDI_X1_5; iq_pc = 32'h500;
    step();
    iq_valid = 1'b0; rob_full = 1'b1;
    #1;
    checks++; if (d_pc !== 32'h500) begin
      errors++; $display("FAIL arst_pre pc=%h exp 500", d_pc); end
    rob_full = 1'b0;
    #1;
    rst = 1'b1;  // mid-cycle, before the next rising edge
    #1;
    checks++; if ({rob_en, rs_en, lsb_en} !== 3'b000 || d_pc !== 32'd0 || d_opnum !== OP_NULL) begin
      errors++; $display("FAIL arst_clear en=%b pc=%h op=%0d exp 000 0 0", {rob_en, rs_en, lsb_en}, d_pc, d_opnum); end
`ifdef DISPATCH_STATS_EN
    checks++; if (stat_dispatch_cnt !== 32'd0 || stat_stall_cnt !== 32'd0) begin
      errors++; $display("FAIL arst_stats got %0d %0d exp 0 0", stat_dispatch_cnt, stat_stall_cnt); end
`endif
    step();
    rst = 1'b0;
    step();
  endtask

  initial begin
    checks = 0; errors = 0;
    rst = 1'b1; rdy = 1'b1; iq_valid = 1'b0; iq_inst = 32'd0; iq_pc = 32'd0;
    iq_pred_jump = 1'b0; rob_full = 1'b0; rs_full = 1'b0; lsb_full = 1'b0;
    rob_free_tag = 4'd0; rollback = 1'b0; jalr_done = 1'b0;
    test_reset();
    test_addi();
    test_store();
    test_stall();
    test_jalr();
    test_rollback();
    test_rdy_low();
    test_async_rst();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
